uart_rx_loader: RTL and testbench

Receives the image over the board's serial line and writes it into the processor's data memory. It is the receive end of the UART link whose transmit end returns processed pixels on `tx`. The block sits between the `rx` pin and the data-RAM write port in `top_processor`. It is armed by the `receive` switch and drives `rx_LED` while a transfer is in progress.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx_core.sv | 98 +++++++++
 rtl/uart_rx_loader.sv | 96 +++++++++
 tb/tb_uart_rx_loader.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and frame constants
package uart_pkg;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_ARMED,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_RESYNC,
        ST_DONE
    } state_t;

    localparam int CLKS_PER_BIT_9600_50M = 5208;
    localparam int DATA_BITS             = 8;
    localparam int STOP_BITS             = 1;

endpackage

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - rx synchronizer and 8N1 bit timing, emits byte and framing-error pulses
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_9600_50M
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 byte_valid,
    output logic                 frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(DATA_BITS - 1);

    logic [1:0]           sync;
    logic                 rxs;
    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic [DATA_BITS-1:0] shreg;

    assign rxs = sync[1];

    // Idle position is ARMED so the first cycle of enable already watches for a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync       <= 2'b11;
            state      <= ST_ARMED;
            cnt        <= '0;
            idx        <= '0;
            shreg      <= '0;
            data       <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            sync       <= {sync[0], rx};
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (!enable) begin
                state <= ST_ARMED;
            end else begin
                case (state)
                    ST_ARMED: begin
                        if (!rxs) begin
                            state <= ST_START;
                            cnt   <= HALF_RELOAD;
                        end
                    end
                    ST_START: begin
                        if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end else if (!rxs) begin
                            state <= ST_DATA;
                            cnt   <= FULL_RELOAD;
                            idx   <= '0;
                        end else begin
                            state <= ST_ARMED;
                        end
                    end
                    ST_DATA: begin
                        if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end else begin
                            shreg[idx] <= rxs;
                            cnt        <= FULL_RELOAD;
                            idx        <= idx + 1'b1;
                            if (idx == LAST_IDX) state <= ST_STOP;
                        end
                    end
                    ST_STOP: begin
                        if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end else if (rxs) begin
                            data       <= shreg;
                            byte_valid <= 1'b1;
                            state      <= ST_ARMED;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= ST_RESYNC;
                        end
                    end
                    ST_RESYNC: begin
                        if (rxs) state <= ST_ARMED;
                    end
                    default: state <= ST_ARMED;
                endcase
            end
        end
    end

endmodule

// File: rtl/uart_rx_loader.sv
// rtl/uart_rx_loader.sv - receives an image over UART and writes it sequentially into data memory
module uart_rx_loader
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_9600_50M,
    parameter int ADDR_W       = 16,
    parameter int NUM_BYTES    = 65536
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              receive,
    input  logic              rx,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              busy,
    output logic              done,
    output logic              frame_err
);

    // One extra bit so a full 2^ADDR_W image can be counted without wrapping.
    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(NUM_BYTES);

    state_t          state;
    logic [ADDR_W:0] byte_cnt;
    logic [ADDR_W:0] cnt_next;
    logic            core_en;
    logic            byte_valid;
    logic            err_pulse;

    assign core_en  = receive && (state == ST_ARMED);
    assign cnt_next = byte_cnt + 1'b1;
    assign mem_we   = byte_valid;

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_core (
        .clk        (clk),
        .reset      (reset),
        .enable     (core_en),
        .rx         (rx),
        .data       (mem_wdata),
        .byte_valid (byte_valid),
        .frame_err  (err_pulse)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_OFF;
            byte_cnt  <= '0;
            mem_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            case (state)
                ST_OFF: begin
                    if (receive) begin
                        state     <= ST_ARMED;
                        busy      <= 1'b1;
                        byte_cnt  <= '0;
                        mem_addr  <= '0;
                        frame_err <= 1'b0;
                    end
                end
                ST_ARMED: begin
                    if (err_pulse) frame_err <= 1'b1;
                    if (byte_valid) begin
                        mem_addr <= mem_addr + 1'b1;
                        byte_cnt <= cnt_next;
                    end
                    if (!receive) begin
                        state <= ST_OFF;
                        busy  <= 1'b0;
                    end else if (byte_valid && cnt_next == LAST_CNT) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!receive) begin
                        state <= ST_OFF;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_OFF;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_loader.sv
// tb/tb_uart_rx_loader.sv - directed self-checking bench for uart_rx_loader
module tb_uart_rx_loader;

    localparam int CPB = 16;

    logic       clk;
    logic       reset;
    logic       receive;
    logic       rx;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic       busy;
    logic       done;
    logic       frame_err;

    int checks;
    int errors;
    int cyc;

    logic [3:0] log_addr[$];
    logic [7:0] log_data[$];
    int         log_cyc[$];

    typedef struct {
        logic       rearm;
        logic [7:0] data;
        logic       stop;
        int         stop_cycles;
        int         exp_we;
        logic [3:0] exp_addr;
        logic       exp_ferr;
        logic       exp_busy;
        logic       exp_done;
    } vec_t;

    vec_t vecs[6];

    uart_rx_loader #(
        .CLKS_PER_BIT (CPB),
        .ADDR_W       (4),
        .NUM_BYTES    (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .receive   (receive),
        .rx        (rx),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .busy      (busy),
        .done      (done),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (mem_we) begin
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_wdata);
            log_cyc.push_back(cyc);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v, input int stop_cycles);
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(b[i], CPB);
        hold(stop_v, stop_cycles);
        rx = 1'b1;
    endtask

    task automatic rearm();
        receive = 1'b0;
        repeat (3) @(negedge clk);
        receive = 1'b1;
        repeat (2) @(negedge clk);
        log_addr.delete();
        log_data.delete();
        log_cyc.delete();
    endtask

    function automatic logic [31:0] wr_addr(input int i);
        return (log_addr.size() > i) ? 32'(log_addr[i]) : 32'hDEAD;
    endfunction

    function automatic logic [31:0] wr_data(input int i);
        return (log_data.size() > i) ? 32'(log_data[i]) : 32'hDEAD;
    endfunction

    initial begin
        checks  = 0;
        errors  = 0;
        cyc     = 0;
        reset   = 1'b1;
        receive = 1'b0;
        rx      = 1'b1;

        vecs[0] = '{1'b0, 8'hA5, 1'b1, CPB,      1, 4'd0, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 8'h3C, 1'b1, CPB,      1, 4'd1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 8'hFF, 1'b1, CPB,      1, 4'd2, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 8'h00, 1'b1, CPB,      1, 4'd3, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 8'hA5, 1'b0, CPB + 48, 0, 4'd0, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 8'h12, 1'b1, CPB,      1, 4'd0, 1'b1, 1'b1, 1'b0};

        repeat (3) @(negedge clk);
        check("reset_addr", 32'(mem_addr), 0);
        check("reset_wdata", 32'(mem_wdata), 0);
        check("reset_we", 32'(mem_we), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_ferr", 32'(frame_err), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_busy", 32'(busy), 0);
        receive = 1'b1;
        repeat (2) @(negedge clk);
        check("armed_busy", 32'(busy), 1);

        for (int v = 0; v < 6; v++) begin
            if (vecs[v].rearm) rearm();
            log_addr.delete();
            log_data.delete();
            log_cyc.delete();
            send_frame(vecs[v].data, vecs[v].stop, vecs[v].stop_cycles);
            repeat (180) @(negedge clk);
            check($sformatf("v%0d_we_count", v), 32'(log_addr.size()), 32'(vecs[v].exp_we));
            if (vecs[v].exp_we != 0) begin
                check($sformatf("v%0d_addr", v), wr_addr(0), 32'(vecs[v].exp_addr));
                check($sformatf("v%0d_data", v), wr_data(0), 32'(vecs[v].data));
            end
            check($sformatf("v%0d_ferr", v), 32'(frame_err), 32'(vecs[v].exp_ferr));
            check($sformatf("v%0d_busy", v), 32'(busy), 32'(vecs[v].exp_busy));
            check($sformatf("v%0d_done", v), 32'(done), 32'(vecs[v].exp_done));
        end

        // glitch on idle line, after re-arm clears the sticky error
        rearm();
        check("rearm_ferr_clear", 32'(frame_err), 0);
        hold(1'b0, 5);
        hold(1'b1, 40);
        check("glitch_we_count", 32'(log_addr.size()), 0);
        check("glitch_ferr", 32'(frame_err), 0);
        check("glitch_busy", 32'(busy), 1);
        send_frame(8'h5A, 1'b1, CPB);
        repeat (40) @(negedge clk);
        check("post_glitch_addr", wr_addr(0), 0);
        check("post_glitch_data", wr_data(0), 32'h5A);

        // abort part-way through the second byte
        rearm();
        send_frame(8'h11, 1'b1, CPB);
        hold(1'b0, CPB);
        for (int i = 0; i < 3; i++) hold(1'b1, CPB);
        receive = 1'b0;
        for (int i = 3; i < 8; i++) hold(1'b1, CPB);
        hold(1'b1, CPB + 40);
        check("abort_we_count", 32'(log_addr.size()), 1);
        check("abort_busy", 32'(busy), 0);
        check("abort_addr", 32'(mem_addr), 1);
        receive = 1'b1;
        repeat (2) @(negedge clk);
        check("rearm_addr", 32'(mem_addr), 0);
        check("rearm_ferr", 32'(frame_err), 0);

        // reset during DATA of byte 3
        rearm();
        send_frame(8'h21, 1'b1, CPB);
        send_frame(8'h22, 1'b1, CPB);
        hold(1'b0, CPB);
        for (int i = 0; i < 3; i++) hold(1'b1, CPB);
        reset   = 1'b1;
        receive = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_addr", 32'(mem_addr), 0);
        check("rst_mid_wdata", 32'(mem_wdata), 0);
        check("rst_mid_we", 32'(mem_we), 0);
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_done", 32'(done), 0);
        check("rst_mid_ferr", 32'(frame_err), 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 3; i < 8; i++) hold(1'b0, CPB);
        hold(1'b1, CPB);
        send_frame(8'h44, 1'b1, CPB);
        repeat (40) @(negedge clk);
        check("rst_ignore_we_count", 32'(log_addr.size()), 2);
        check("rst_ignore_busy", 32'(busy), 0);
        receive = 1'b1;
        repeat (2) @(negedge clk);
        send_frame(8'h33, 1'b1, CPB);
        repeat (40) @(negedge clk);
        check("rst_rearm_addr", wr_addr(2), 0);
        check("rst_rearm_data", wr_data(2), 32'h33);

        // back-to-back frames, no idle bits between them
        rearm();
        send_frame(8'h81, 1'b1, CPB);
        send_frame(8'h7E, 1'b1, CPB);
        repeat (40) @(negedge clk);
        check("b2b_we_count", 32'(log_addr.size()), 2);
        check("b2b_addr0", wr_addr(0), 0);
        check("b2b_data0", wr_data(0), 32'h81);
        check("b2b_addr1", wr_addr(1), 1);
        check("b2b_data1", wr_data(1), 32'h7E);
        check("b2b_spacing", (log_cyc.size() > 1) ? 32'(log_cyc[1] - log_cyc[0]) : 32'hDEAD, 160);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
